adder_scheduler: RTL and testbench

ADDER_SCHEDULER -- requirements
Module: adder_scheduler

---
 rtl/adder_sched_pkg.sv | 16 +
 rtl/brent_kung_adder.sv | 32 +++
 rtl/rr_arbiter.sv | 29 ++
 rtl/adder_scheduler.sv | 95 +++++++++
 tb/tb_adder_scheduler.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/adder_sched_pkg.sv
// rtl/adder_sched_pkg.sv - shared types and constants for the adder scheduler
package adder_sched_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam int N_REQ_DEF = 4;
    localparam int W_DEF     = 32;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/brent_kung_adder.sv
// rtl/brent_kung_adder.sv - 32-bit Brent-Kung prefix adder, carry-in 0, no carry-out
module brent_kung_adder (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] sum_o
);

    logic [31:0] p;
    logic [31:0] gg;
    logic [31:0] pp;

    always_comb begin
        p  = a_i ^ b_i;
        gg = a_i & b_i;
        pp = p;
        // Up-sweep builds prefixes at 2^k-1; down-sweep fills the remaining positions.
        for (int d = 1; d < 32; d = d * 2) begin
            for (int i = 2 * d - 1; i < 32; i = i + 2 * d) begin
                gg[5'(i)] = gg[5'(i)] | (pp[5'(i)] & gg[5'(i - d)]);
                pp[5'(i)] = pp[5'(i)] & pp[5'(i - d)];
            end
        end
        for (int d = 8; d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < 32; i = i + 2 * d) begin
                gg[5'(i)] = gg[5'(i)] | (pp[5'(i)] & gg[5'(i - d)]);
                pp[5'(i)] = pp[5'(i)] & pp[5'(i - d)];
            end
        end
        sum_o = p ^ {gg[30:0], 1'b0};
    end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin selector starting at ptr, one-hot grant plus index
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          any_o
);

    logic [IW-1:0] idx;

    always_comb begin
        gnt_idx_o = '0;
        any_o     = 1'b0;
        idx       = ptr_i;
        for (int k = 0; k < N; k++) begin
            if (!any_o && req_i[idx]) begin
                any_o     = 1'b1;
                gnt_idx_o = idx;
            end
            idx = (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
        end
        gnt_o = any_o ? (N'(1) << gnt_idx_o) : '0;
    end

endmodule

// File: rtl/adder_scheduler.sv
// rtl/adder_scheduler.sv - round-robin sharing of one 32-bit adder among N_REQ requesters
module adder_scheduler
    import adder_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*W-1:0]            req_a,
    input  logic [N_REQ*W-1:0]            req_b,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [id_width(N_REQ)-1:0]    rsp_id,
    output logic [W-1:0]                  rsp_sum
);

    localparam int IW = id_width(N_REQ);

    state_t          state_q;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   rsp_id_q;
    logic [W-1:0]    rsp_sum_q, rsp_sum_d;
    logic [N_REQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            any;
    logic            free;
    logic            xfer;
    logic [W-1:0]    a_arr [N_REQ];
    logic [W-1:0]    b_arr [N_REQ];
    logic [31:0]     op_a, op_b, sum;

    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign a_arr[k] = req_a[k*W +: W];
        assign b_arr[k] = req_b[k*W +: W];
    end

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_arb (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_o     (any)
    );

    assign op_a = 32'(a_arr[gnt_idx]);
    assign op_b = 32'(b_arr[gnt_idx]);

    brent_kung_adder u_add (
        .a_i   (op_a),
        .b_i   (op_b),
        .sum_o (sum)
    );

    // Gating on rst keeps grants silent during reset even though the state is already EMPTY.
    assign free      = (state_q == ST_EMPTY) || rsp_ready;
    assign xfer      = free && any && !rst;
    assign req_ready = xfer ? gnt : '0;
    assign ptr_d     = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    assign rsp_sum_d = sum[W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            ptr_q     <= '0;
            rsp_id_q  <= '0;
            rsp_sum_q <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (xfer) state_q <= ST_FULL;
                end
                ST_FULL: begin
                    if (rsp_ready && !xfer) state_q <= ST_EMPTY;
                end
                default: state_q <= ST_EMPTY;
            endcase
            if (xfer) begin
                ptr_q     <= ptr_d;
                rsp_id_q  <= gnt_idx;
                rsp_sum_q <= rsp_sum_d;
            end
        end
    end

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;

endmodule

// File: tb/tb_adder_scheduler.sv
// tb/tb_adder_scheduler.sv - directed-vector bench for adder_scheduler
module tb_adder_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_a, req_b;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_sum;
    logic [31:0]  op_a [4];
    logic [31:0]  op_b [4];

    int n_checks = 0;
    int n_pass   = 0;

    assign req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
    assign req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

    always #5 clk = ~clk;

    adder_scheduler #(.N_REQ(4), .W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    int          exp_g [5] = '{0, 1, 2, 3, 0};
    logic [31:0] exp_s [5] = '{32'h1003, 32'h2004, 32'h3005, 32'h4006, 32'h1003};

    initial begin
        rst       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        op_a[0] = 32'd5; op_b[0] = 32'd7;
        op_a[1] = 32'd0; op_b[1] = 32'd0;
        op_a[2] = 32'd0; op_b[2] = 32'd0;
        op_a[3] = 32'd0; op_b[3] = 32'd0;
        #2;
        check("reset_valid", 64'(rsp_valid), 64'd0);
        check("reset_id", 64'(rsp_id), 64'd0);
        check("reset_sum", 64'(rsp_sum), 64'd0);
        check("reset_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        check("reset_edge_valid", 64'(rsp_valid), 64'd0);

        // single request, first cycle after reset release
        @(negedge clk);
        rst = 1'b0; req_valid = 4'b0001;
        #1 check("single_ready", 64'(req_ready), 64'b0001);
        @(posedge clk); #1;
        check("single_valid", 64'(rsp_valid), 64'd1);
        check("single_id", 64'(rsp_id), 64'd0);
        check("single_sum", 64'(rsp_sum), 64'd12);

        // wrap-around sum, back-to-back with the previous result
        @(negedge clk);
        op_a[0] = 32'hFFFF_FFFF; op_b[0] = 32'h0000_0002;
        #1 check("wrap_ready", 64'(req_ready), 64'b0001);
        @(posedge clk); #1;
        check("wrap_valid", 64'(rsp_valid), 64'd1);
        check("wrap_id", 64'(rsp_id), 64'd0);
        check("wrap_sum", 64'(rsp_sum), 64'h1);

        @(negedge clk);
        req_valid = 4'b0000;
        #1 check("idle_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        check("drain_valid", 64'(rsp_valid), 64'd0);

        // fairness from a fresh pointer
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req_valid = 4'b1111;
        op_a[0] = 32'h1000; op_b[0] = 32'd3;
        op_a[1] = 32'h2000; op_b[1] = 32'd4;
        op_a[2] = 32'h3000; op_b[2] = 32'd5;
        op_a[3] = 32'h4000; op_b[3] = 32'd6;
        for (int k = 0; k < 5; k++) begin
            #1 check("fair_ready", 64'(req_ready), 64'(4'b0001 << exp_g[k]));
            @(posedge clk); #1;
            check("fair_valid", 64'(rsp_valid), 64'd1);
            check("fair_id", 64'(rsp_id), 64'(exp_g[k]));
            check("fair_sum", 64'(rsp_sum), 64'(exp_s[k]));
            @(negedge clk);
        end

        // backpressure: hold 12, then release into requester 1
        req_valid = 4'b0001; op_a[0] = 32'd5; op_b[0] = 32'd7;
        #1 check("bp_setup_ready", 64'(req_ready), 64'b0001);
        @(posedge clk); #1;
        check("bp_setup_sum", 64'(rsp_sum), 64'd12);
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 4'b0010;
        for (int k = 0; k < 2; k++) begin
            #1 check("bp_ready", 64'(req_ready), 64'd0);
            @(posedge clk); #1;
            check("bp_hold_valid", 64'(rsp_valid), 64'd1);
            check("bp_hold_id", 64'(rsp_id), 64'd0);
            check("bp_hold_sum", 64'(rsp_sum), 64'd12);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1 check("bp_release_ready", 64'(req_ready), 64'b0010);
        @(posedge clk); #1;
        check("bp_release_id", 64'(rsp_id), 64'd1);
        check("bp_release_sum", 64'(rsp_sum), 64'h2004);

        // pointer at 2 skips to 3, then wraps to 0
        @(negedge clk);
        req_valid = 4'b1001; op_a[3] = 32'd100; op_b[3] = 32'd23;
        #1 check("skip_ready_3", 64'(req_ready), 64'b1000);
        @(posedge clk); #1;
        check("skip_id_3", 64'(rsp_id), 64'd3);
        check("skip_sum_3", 64'(rsp_sum), 64'd123);
        @(negedge clk);
        #1 check("skip_ready_0", 64'(req_ready), 64'b0001);
        @(posedge clk); #1;
        check("skip_id_0", 64'(rsp_id), 64'd0);
        check("skip_sum_0", 64'(rsp_sum), 64'd12);

        // reset while a result is held, checked before any clock edge
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_valid", 64'(rsp_valid), 64'd0);
        check("midrst_id", 64'(rsp_id), 64'd0);
        check("midrst_sum", 64'(rsp_sum), 64'd0);
        check("midrst_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0; req_valid = 4'b1111;
        #1 check("postrst_ready", 64'(req_ready), 64'b0001);
        @(posedge clk); #1;
        check("postrst_valid", 64'(rsp_valid), 64'd1);
        check("postrst_id", 64'(rsp_id), 64'd0);
        check("postrst_sum", 64'(rsp_sum), 64'd12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
